// File: rtl/ysyx_exec_sequencer.sv
// Multi-cycle FETCH/DECODE/MEM/WB control sequencer with ebreak halt and retired-instruction counter.
// Optional fetch/memory wait timeout is built only when YSYX_SEQ_TIMEOUT_EN is defined.
module ysyx_exec_sequencer #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ifu_req,
    input  logic        ifu_rvalid,
    output logic        ir_we,
    input  logic        dec_rf_wr_en,
    input  logic [2:0]  dec_dm_rd_sel,
    input  logic [1:0]  dec_dm_wr_sel,
    input  logic        dec_ebreak,
    output logic        lsu_req,
    output logic        lsu_we,
    input  logic        lsu_rvalid,
    output logic        rf_we,
    output logic        pc_we,
    output logic        halted,
    output logic        bus_err,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_instret;
    logic        w_mem_op;
    logic        w_is_store;
    logic        w_timeout;

    assign w_is_store = |dec_dm_wr_sel;
    assign w_mem_op   = w_is_store | (|dec_dm_rd_sel);

`ifdef YSYX_SEQ_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_wait_cnt;
    logic       r_bus_err;
    logic       w_waiting;

    // A response in the cycle the limit is reached wins, so only an absent response can time out.
    assign w_waiting = ((r_state == S_FETCH) && !ifu_rvalid) ||
                       ((r_state == S_MEM)   && !lsu_rvalid);
    assign w_timeout = w_waiting && (r_wait_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 8'd0;
        end else if (w_next != r_state) begin
            r_wait_cnt <= 8'd0;
        end else if (w_waiting) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_err <= 1'b0;
        end else if (w_timeout) begin
            r_bus_err <= 1'b1;
        end
    end

    assign bus_err = r_bus_err;
`else
    assign w_timeout = 1'b0;
    assign bus_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        ifu_req = 1'b0;
        ir_we   = 1'b0;
        lsu_req = 1'b0;
        lsu_we  = 1'b0;
        rf_we   = 1'b0;
        pc_we   = 1'b0;
        halted  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                ifu_req = 1'b1;
                if (ifu_rvalid) begin
                    ir_we  = 1'b1;
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_HALT;
                end
            end
            S_DECODE: begin
                if (dec_ebreak) begin
                    w_next = S_HALT;
                end else if (w_mem_op) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                lsu_req = 1'b1;
                lsu_we  = w_is_store;
                if (lsu_rvalid) begin
                    w_next = S_WB;
                end else if (w_timeout) begin
                    w_next = S_HALT;
                end
            end
            S_WB: begin
                rf_we  = dec_rf_wr_en;
                pc_we  = 1'b1;
                w_next = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= 32'd0;
        end else if (r_state == S_WB) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    assign instret = r_instret;

endmodule

// File: tb/tb_ysyx_exec_sequencer.sv
// Scoreboard bench for ysyx_exec_sequencer: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_ysyx_exec_sequencer;

`ifdef YSYX_SEQ_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    localparam int EV_FET  = 0;
    localparam int EV_MEM  = 1;
    localparam int EV_RET  = 2;
    localparam int EV_HALT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_req, ir_we, lsu_req, lsu_we, rf_we, pc_we, halted, bus_err;
    logic        ifu_rvalid = 1'b0;
    logic        lsu_rvalid = 1'b0;
    logic        dec_rf_wr_en = 1'b0;
    logic [2:0]  dec_dm_rd_sel = 3'd0;
    logic [1:0]  dec_dm_wr_sel = 2'd0;
    logic        dec_ebreak = 1'b0;
    logic [31:0] instret;

    typedef struct {
        int kind;
        int a;
        int b;
    } ev_t;

    ev_t exp_q[$];
    int  n_chk = 0;
    int  n_fail = 0;
    int  m_instret = 0;

    always #5 clk = ~clk;

    ysyx_exec_sequencer #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req(ifu_req), .ifu_rvalid(ifu_rvalid), .ir_we(ir_we),
        .dec_rf_wr_en(dec_rf_wr_en), .dec_dm_rd_sel(dec_dm_rd_sel),
        .dec_dm_wr_sel(dec_dm_wr_sel), .dec_ebreak(dec_ebreak),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_rvalid(lsu_rvalid),
        .rf_we(rf_we), .pc_we(pc_we), .halted(halted), .bus_err(bus_err),
        .instret(instret)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int kind, input int a, input int b);
        ev_t e;
        e.kind = kind; e.a = a; e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input int kind, input int a, input int b, input bit use_b);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event_kind", kind, -1);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_a", a, e.a);
            if (use_b) chk("event_b", b, e.b);
        end
    endtask

    // Monitor: turns DUT handshakes into events and matches them against the scoreboard.
    initial begin
        int  fcnt = 0;
        int  mcnt = 0;
        logic prev_halt = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                fcnt = 0; mcnt = 0; prev_halt = 1'b0;
            end else begin
                if (ifu_req) begin
                    fcnt++;
                    if (ifu_rvalid) begin
                        chk("ir_we_mealy", int'(ir_we), 1);
                        pop_chk(EV_FET, fcnt, 0, 1'b0);
                        fcnt = 0;
                    end
                end else begin
                    fcnt = 0;
                end
                if (lsu_req) begin
                    mcnt++;
                    if (lsu_rvalid) begin
                        pop_chk(EV_MEM, mcnt, int'(lsu_we), 1'b1);
                        mcnt = 0;
                    end
                end else begin
                    mcnt = 0;
                end
                if (pc_we) pop_chk(EV_RET, int'(rf_we), int'(instret), 1'b1);
                if (halted && !prev_halt) pop_chk(EV_HALT, int'(bus_err), 0, 1'b0);
                prev_halt = halted;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int outs();
        return int'({ifu_req, ir_we, lsu_req, lsu_we, rf_we, pc_we, halted, bus_err});
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        ifu_rvalid = 1'b0; lsu_rvalid = 1'b0;
        dec_rf_wr_en = 1'b0; dec_dm_rd_sel = 3'd0; dec_dm_wr_sel = 2'd0; dec_ebreak = 1'b0;
        repeat (2) tick();
        chk("reset_outputs", outs(), 0);
        chk("reset_instret", int'(instret), 0);
        rst_n = 1'b1;
        m_instret = 0;
        chk("idle_no_ifu_req", int'(ifu_req), 0);
        tick();
        chk("ifu_req_after_edge1", int'(ifu_req), 1);
    endtask

    task automatic wait_fetch();
        int n = 0;
        while (!ifu_req && n < 50) begin
            tick();
            n++;
        end
        chk("wait_ifu_req", int'(ifu_req), 1);
    endtask

    // One instruction: fetch after fd wait cycles, memory after md wait cycles (respond=0 never answers).
    task automatic run_instr(input int fd, input int md, input logic [2:0] rd, input logic [1:0] wr,
                             input logic rfw, input logic ebk, input bit respond);
        wait_fetch();
        push(EV_FET, fd + 1, 0);
        repeat (fd) tick();
        ifu_rvalid = 1'b1;
        dec_dm_rd_sel = rd; dec_dm_wr_sel = wr; dec_rf_wr_en = rfw; dec_ebreak = ebk;
        tick();
        ifu_rvalid = 1'b0;
        if (ebk) begin
            push(EV_HALT, 0, 0);
            tick();
            return;
        end
        if (rd != 3'd0 || wr != 2'd0) begin
            if (!respond) begin
                push(EV_HALT, 1, 0);
                tick();
                repeat (TO) tick();
                return;
            end
            push(EV_MEM, md + 1, int'(wr != 2'd0));
            tick();
            repeat (md) tick();
            lsu_rvalid = 1'b1;
            tick();
            lsu_rvalid = 1'b0;
        end else begin
            tick();
        end
        push(EV_RET, int'(rfw), m_instret);
        tick();
        m_instret++;
    endtask

    initial begin
        do_reset();
        // three zero-wait ALU ops: retire in cycles 3, 6, 9
        for (int i = 0; i < 3; i++) run_instr(0, 0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b1);
        chk("instret_after_3_alu", int'(instret), 3);
        run_instr(2, 3, 3'd4, 2'd0, 1'b1, 1'b0, 1'b1);
        run_instr(0, 0, 3'd0, 2'd3, 1'b0, 1'b0, 1'b1);
        // both selects set: must be treated as a store
        run_instr(1, 0, 3'd2, 2'd1, 1'b0, 1'b0, 1'b1);
        chk("instret_after_mem", int'(instret), 6);

        // reset in the middle of a load
        wait_fetch();
        push(EV_FET, 1, 0);
        ifu_rvalid = 1'b1; dec_dm_rd_sel = 3'd4; dec_dm_wr_sel = 2'd0; dec_rf_wr_en = 1'b1;
        tick();
        ifu_rvalid = 1'b0;
        tick();
        chk("in_mem_lsu_req", int'(lsu_req), 1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", outs(), 0);
        chk("async_reset_instret", int'(instret), 0);
        lsu_rvalid = 1'b1;
        tick();
        chk("reset_ignores_rvalid", outs(), 0);
        lsu_rvalid = 1'b0;
        rst_n = 1'b1;
        m_instret = 0;
        chk("restart_idle", int'(ifu_req), 0);
        tick();
        chk("restart_fetch", int'(ifu_req), 1);
        run_instr(0, 0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b1);
        chk("instret_after_restart", int'(instret), 1);

        // ebreak halts; fetch responses afterwards are ignored
        run_instr(0, 0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b1);
        chk("ebreak_halted", int'(halted), 1);
        chk("ebreak_instret", int'(instret), 1);
        for (int i = 0; i < 6; i++) begin
            ifu_rvalid = ~ifu_rvalid;
            lsu_rvalid = ~lsu_rvalid;
            #1;
            chk("halt_quiet", int'({ifu_req, ir_we, lsu_req, pc_we, rf_we}), 0);
            tick();
        end
        ifu_rvalid = 1'b0; lsu_rvalid = 1'b0;
        chk("halt_no_bus_err", int'(bus_err), 0);
        chk("halt_sticky", int'(halted), 1);

`ifdef YSYX_SEQ_TIMEOUT_EN
        do_reset();
        run_instr(0, 0, 3'd4, 2'd0, 1'b1, 1'b0, 1'b0);
        chk("timeout_bus_err", int'(bus_err), 1);
        chk("timeout_halted", int'(halted), 1);
        do_reset();
        run_instr(0, TO - 1, 3'd4, 2'd0, 1'b1, 1'b0, 1'b1);
        chk("late_resp_no_err", int'(bus_err), 0);
        chk("late_resp_instret", int'(instret), 1);
`endif

        repeat (4) tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
